// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_inst_buf.sv
// Single-entry holding register for the instruction offered to decode.
// Handshake: a word transfers on a clock edge where valid && ready; flush drops it.
module fetch_inst_buf
  import fetch_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [WORD_W-1:0] load_pc,
  input  logic              ready,
  input  logic              flush,
  output logic              valid,
  output logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] pc
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (flush || (valid && ready)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, redirect-aware.
// Optional FETCH_CTRL_HALT_EN adds halt/halted ports that stall new requests.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
`ifdef FETCH_CTRL_HALT_EN
  input  logic              halt,
  output logic              halted,
`endif
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [WORD_W-1:0] mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WORD_W-1:0] inst_data,
  output logic [WORD_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_target,
  output fetch_state_t      fsm_state
);

  fetch_state_t      state, state_next;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] inflight_addr;
  logic              discard;
  logic              halt_req;
  logic              req_fire;
  logic              rsp_take;
  logic              buf_flush;

`ifdef FETCH_CTRL_HALT_EN
  assign halt_req = halt;
  assign halted   = (state == REQ) && halt;
`else
  assign halt_req = 1'b0;
`endif

  assign req_fire  = mem_req_valid && mem_req_ready;
  assign rsp_take  = (state == WAIT) && mem_rsp_valid && !discard && !redirect;
  assign buf_flush = (state == HOLD) && redirect;
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ:  if (req_fire) state_next = WAIT;
      // A response under redirect or pending discard is dropped and we refetch.
      WAIT: if (mem_rsp_valid) state_next = (redirect || discard) ? REQ : HOLD;
      HOLD: if (redirect || inst_ready) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = (state == REQ) && !halt_req;
    mem_addr      = pc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_PC;
      inflight_addr <= '0;
      discard       <= 1'b0;
    end else begin
      if (state != IDLE && redirect) pc <= redirect_target;
      else if (req_fire)             pc <= pc + 16'd1;

      if (req_fire) begin
        inflight_addr <= pc;
        discard       <= redirect;
      end else if (state == WAIT) begin
        if (mem_rsp_valid) discard <= 1'b0;
        else if (redirect) discard <= 1'b1;
      end
    end
  end

  fetch_inst_buf u_inst_buf (
    .clock     (clock),
    .reset     (reset),
    .load      (rsp_take),
    .load_data (mem_rsp_data),
    .load_pc   (inflight_addr),
    .ready     (inst_ready),
    .flush     (buf_flush),
    .valid     (inst_valid),
    .data      (inst_data),
    .pc        (inst_pc)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (halt tests when FETCH_CTRL_HALT_EN is defined).
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic         clock;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [15:0]  mem_addr;
  logic         mem_rsp_valid;
  logic [15:0]  mem_rsp_data;
  logic         inst_valid;
  logic         inst_ready;
  logic [15:0]  inst_data;
  logic [15:0]  inst_pc;
  logic         redirect;
  logic [15:0]  redirect_target;
  fetch_state_t fsm_state;
`ifdef FETCH_CTRL_HALT_EN
  logic         halt;
  logic         halted;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(.RESET_PC(16'h0000)) dut (
    .clock           (clock),
    .reset           (reset),
`ifdef FETCH_CTRL_HALT_EN
    .halt            (halt),
    .halted          (halted),
`endif
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_addr        (mem_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fsm_state       (fsm_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full zero-wait fetch starting in REQ at address a; returns in REQ.
  task automatic fetch_one(input logic [15:0] a);
    check("req_valid", {15'b0, mem_req_valid}, 16'd1);
    check("req_addr", mem_addr, a);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("wait_no_req", {15'b0, mem_req_valid}, 16'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = a ^ 16'h5A5A;
    step();
    mem_rsp_valid = 1'b0;
    check("inst_valid", {15'b0, inst_valid}, 16'd1);
    check("inst_data", inst_data, a ^ 16'h5A5A);
    check("inst_pc", inst_pc, a);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("inst_popped", {15'b0, inst_valid}, 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
`ifdef FETCH_CTRL_HALT_EN
    halt = 1'b0;
`endif
    #2 reset = 1'b0;
    #1;
    check("rst_state", {14'b0, fsm_state}, {14'b0, IDLE});
    check("rst_req_valid", {15'b0, mem_req_valid}, 16'd0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_inst_valid", {15'b0, inst_valid}, 16'd0);
    check("rst_inst_data", inst_data, 16'h0000);
    check("rst_inst_pc", inst_pc, 16'h0000);
    step();
    step();
    reset = 1'b1;
    check("idle_no_req", {15'b0, mem_req_valid}, 16'd0);
    step();

    // Sequential fetch from reset
    fetch_one(16'h0000);
    fetch_one(16'h0001);
    fetch_one(16'h0002);

    // Wrap at FFFF
    redirect = 1'b1;
    redirect_target = 16'hFFFF;
    step();
    redirect = 1'b0;
    fetch_one(16'hFFFF);
    fetch_one(16'h0000);

    // Redirect coincident with request acceptance drops that response
    redirect = 1'b1;
    redirect_target = 16'h0005;
    step();
    redirect = 1'b0;
    check("redir_req_addr", mem_addr, 16'h0005);
    mem_req_ready = 1'b1;
    redirect = 1'b1;
    redirect_target = 16'h0200;
    step();
    mem_req_ready = 1'b0;
    redirect = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 16'h1234;
    step();
    mem_rsp_valid = 1'b0;
    check("drop_0005_valid", {15'b0, inst_valid}, 16'd0);
    fetch_one(16'h0200);

    // Redirect in WAIT together with the response
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    redirect = 1'b1;
    redirect_target = 16'h0300;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 16'h1111;
    step();
    redirect = 1'b0;
    mem_rsp_valid = 1'b0;
    check("wait_redir_same_valid", {15'b0, inst_valid}, 16'd0);
    fetch_one(16'h0300);

    // Redirect in WAIT, response arrives later and is discarded
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    redirect = 1'b1;
    redirect_target = 16'h0400;
    step();
    redirect = 1'b0;
    check("wait_redir_still_wait", {15'b0, mem_req_valid}, 16'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 16'h2222;
    step();
    mem_rsp_valid = 1'b0;
    check("late_rsp_dropped", {15'b0, inst_valid}, 16'd0);
    fetch_one(16'h0400);

    // HOLD stall for 4 cycles
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 16'hBEEF;
    step();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", {15'b0, inst_valid}, 16'd1);
      check("hold_data", inst_data, 16'hBEEF);
      check("hold_pc", inst_pc, 16'h0401);
      check("hold_no_req", {15'b0, mem_req_valid}, 16'd0);
      step();
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("hold_release", {15'b0, inst_valid}, 16'd0);
    check("after_hold_addr", mem_addr, 16'h0402);

    // Redirect in HOLD flushes the instruction
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 16'h3333;
    step();
    mem_rsp_valid = 1'b0;
    check("hold2_valid", {15'b0, inst_valid}, 16'd1);
    redirect = 1'b1;
    redirect_target = 16'h0500;
    step();
    redirect = 1'b0;
    check("hold_flush", {15'b0, inst_valid}, 16'd0);
    check("hold_flush_addr", mem_addr, 16'h0500);

    // Response outside WAIT is ignored
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 16'h4444;
    step();
    mem_rsp_valid = 1'b0;
    check("rsp_in_req_ignored", {15'b0, inst_valid}, 16'd0);
    check("rsp_in_req_addr", mem_addr, 16'h0500);

    // Reset during WAIT
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_req_valid", {15'b0, mem_req_valid}, 16'd0);
    check("mid_rst_addr", mem_addr, 16'h0000);
    check("mid_rst_inst_data", inst_data, 16'h0000);
    check("mid_rst_inst_pc", inst_pc, 16'h0000);
    step();
    reset = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 16'hDEAD;
    step();
    check("post_rst_rsp1", {15'b0, inst_valid}, 16'd0);
    step();
    mem_rsp_valid = 1'b0;
    check("post_rst_rsp2", {15'b0, inst_valid}, 16'd0);
    fetch_one(16'h0000);

`ifdef FETCH_CTRL_HALT_EN
    halt = 1'b1;
    #1;
    check("halted", {15'b0, halted}, 16'd1);
    check("halt_no_req", {15'b0, mem_req_valid}, 16'd0);
    step();
    step();
    check("halt_held_addr", mem_addr, 16'h0001);
    check("halt_no_req2", {15'b0, mem_req_valid}, 16'd0);
    halt = 1'b0;
    #1;
    check("unhalted", {15'b0, halted}, 16'd0);
`endif
    fetch_one(16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
